// File: rtl/uart_header_rx_if.sv
// Receive-side signal bundle for uart_header_rx: uart byte handshake plus header valid/ack.
// master = framer (drives rdy_clr and header outputs), slave = uart/core side.
interface uart_header_rx_if #(
    parameter int unsigned HEADER_BYTES = 80
);
    logic [7:0]                  rx_byte;
    logic                        rx_rdy;
    logic                        rdy_clr;
    logic [8*HEADER_BYTES-1:0]   header_data;
    logic                        header_valid;
    logic                        header_ack;
    logic                        frame_error;
    logic                        busy;

    modport master (
        input  rx_byte, rx_rdy, header_ack,
        output rdy_clr, header_data, header_valid, frame_error, busy
    );

    modport slave (
        output rx_byte, rx_rdy, header_ack,
        input  rdy_clr, header_data, header_valid, frame_error, busy
    );
endinterface

// File: rtl/uart_header_rx.sv
// Sync-hunting framer: assembles HEADER_BYTES-byte headers from uart bytes, valid/ack output.
// Optional trailing XOR checksum byte enabled by defining UART_HEADER_CHECKSUM_EN.
module uart_header_rx #(
    parameter int unsigned HEADER_BYTES   = 80,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 20
) (
    input  logic              clock,
    input  logic              reset,
    uart_header_rx_if.master  bus
);
    localparam int unsigned W     = 8 * HEADER_BYTES;
    localparam int unsigned CNT_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;

`ifdef UART_HEADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, CHECK = 2'd2, HOLD = 2'd3} state_t;
    localparam int unsigned SH_W = W;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd3} state_t;
    // Without CHECK the last byte commits straight from the shift path, so the
    // shadow only needs to hold the first HEADER_BYTES-1 bytes.
    localparam int unsigned SH_W = W - 8;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [SH_W-1:0]    shadow_q;
    logic [W-1:0]       header_q;
    logic [TO_W-1:0]    to_q;
    logic               rdy_clr_q;
    logic               seen_q;
    logic               valid_q;
    logic               ferr_q;
    logic               busy_q;
`ifdef UART_HEADER_CHECKSUM_EN
    logic [7:0]         xor_q;
`endif

    logic               accept;
    logic               timeout_hit;
    logic               last_byte;
    logic [W-1:0]       shifted;

    // seen_q blocks a second accept of the same byte if rdy stays high past rdy_clr.
    assign accept      = bus.rx_rdy && !rdy_clr_q && !seen_q;
    assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 2));
    assign last_byte   = (count_q == CNT_W'(HEADER_BYTES - 1));
`ifdef UART_HEADER_CHECKSUM_EN
    assign shifted     = {shadow_q[W-9:0], bus.rx_byte};
`else
    assign shifted     = {shadow_q, bus.rx_byte};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            header_q  <= '0;
            to_q      <= '0;
            rdy_clr_q <= 1'b0;
            seen_q    <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_HEADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            rdy_clr_q <= accept;
            ferr_q    <= 1'b0;
            if (accept)
                seen_q <= 1'b1;
            else if (!bus.rx_rdy)
                seen_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    to_q <= '0;
                    if (accept && bus.rx_byte == SYNC_BYTE) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                        count_q <= '0;
`ifdef UART_HEADER_CHECKSUM_EN
                        xor_q   <= '0;
`endif
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        to_q     <= '0;
                        shadow_q <= shifted[SH_W-1:0];
                        count_q  <= count_q + CNT_W'(1);
`ifdef UART_HEADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ bus.rx_byte;
                        if (last_byte)
                            state_q <= CHECK;
`else
                        if (last_byte) begin
                            header_q <= shifted;
                            valid_q  <= 1'b1;
                            state_q  <= HOLD;
                        end
`endif
                    end else if (timeout_hit) begin
                        ferr_q   <= 1'b1;
                        shadow_q <= '0;
                        to_q     <= '0;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end

`ifdef UART_HEADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        to_q <= '0;
                        if (bus.rx_byte == xor_q) begin
                            header_q <= shadow_q;
                            valid_q  <= 1'b1;
                            state_q  <= HOLD;
                        end else begin
                            ferr_q   <= 1'b1;
                            shadow_q <= '0;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        ferr_q   <= 1'b1;
                        shadow_q <= '0;
                        to_q     <= '0;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
`endif

                HOLD: begin
                    to_q <= '0;
                    if (bus.header_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy_clr      = rdy_clr_q;
    assign bus.header_data  = header_q;
    assign bus.header_valid = valid_q;
    assign bus.frame_error  = ferr_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_uart_header_rx.sv
// Directed bench for uart_header_rx (TIMEOUT_CYCLES=100); checksum section active
// when UART_HEADER_CHECKSUM_EN is defined.
module tb_uart_header_rx;
    localparam int unsigned HB = 80;
    localparam int unsigned W  = 8 * HB;
`ifdef UART_HEADER_CHECKSUM_EN
    localparam int FRAME_BYTES = HB + 2;
`else
    localparam int FRAME_BYTES = HB + 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_header_rx_if #(.HEADER_BYTES(HB)) bus ();

    uart_header_rx #(
        .HEADER_BYTES  (HB),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100),
        .TO_W          (7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int rdy_cnt  = 0;
    int ferr_cnt = 0;

    always @(posedge clock) begin
        if (bus.rdy_clr)     rdy_cnt++;
        if (bus.frame_error) ferr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_hold(input logic [7:0] b, input int n);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        repeat (n) tick();
        bus.rx_rdy  = 1'b0;
        tick();
    endtask

    task automatic send_last(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        chk("valid_before_last", W'(bus.header_valid), W'(0));
        tick();
        chk("valid_latency", W'(bus.header_valid), W'(1));
        chk("rdy_clr_last", W'(bus.rdy_clr), W'(1));
        bus.rx_rdy = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] start, input int sync_n, output logic [W-1:0] exp);
        logic [7:0] b;
        logic [7:0] x;
        exp = '0;
        x   = '0;
        send_hold(8'hA5, sync_n);
        for (int i = 0; i < int'(HB); i++) begin
            b = start + 8'(i);
            exp[W-1-8*i -: 8] = b;
            x = x ^ b;
            if (i < int'(HB) - 1) send_hold(b, 1);
        end
`ifdef UART_HEADER_CHECKSUM_EN
        send_hold(b, 1);
        send_last(x);
`else
        send_last(b);
`endif
    endtask

    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
    int r0;
    int f0;
    int n;

    initial begin
        bus.rx_byte    = '0;
        bus.rx_rdy     = 1'b0;
        bus.header_ack = 1'b0;
        reset          = 1'b0;
        repeat (3) tick();
        chk("rst_header_data", bus.header_data, '0);
        chk("rst_valid", W'(bus.header_valid), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_rdy_clr", W'(bus.rdy_clr), W'(0));
        chk("rst_frame_error", W'(bus.frame_error), W'(0));
        reset = 1'b1;
        tick();

        // Leading non-sync byte dropped, then 01..50 frame.
        r0 = rdy_cnt;
        send_hold(8'h00, 1);
        chk("drop_non_sync_busy", W'(bus.busy), W'(0));
        send_frame(8'h01, 1, exp1);
        chk("hdr_full", bus.header_data, exp1);
        chk("hdr_first_byte", W'(bus.header_data[W-1 -: 8]), W'(8'h01));
        chk("hdr_last_byte", W'(bus.header_data[7:0]), W'(8'h50));
        chk("frame_rdy_clr_count", W'(rdy_cnt - r0), W'(FRAME_BYTES + 1));
        chk("hold_busy", W'(bus.busy), W'(1));

        // Long hold with extra bytes arriving.
        repeat (1000) tick();
        r0 = rdy_cnt;
        for (int i = 0; i < 5; i++) send_hold(8'hA5 + 8'(i), 1);
        chk("hold_hdr_frozen", bus.header_data, exp1);
        chk("hold_valid", W'(bus.header_valid), W'(1));
        chk("hold_rdy_clr_count", W'(rdy_cnt - r0), W'(5));
        bus.header_ack = 1'b1;
        tick();
        bus.header_ack = 1'b0;
        chk("ack_valid_low", W'(bus.header_valid), W'(0));
        chk("ack_busy_low", W'(bus.busy), W'(0));

        // Timeout after sync + 40 bytes.
        f0 = ferr_cnt;
        send_hold(8'hA5, 1);
        for (int i = 0; i < 39; i++) send_hold(8'h10 + 8'(i), 1);
        bus.rx_byte = 8'h10 + 8'd39;
        bus.rx_rdy  = 1'b1;
        tick();
        bus.rx_rdy = 1'b0;
        n = 0;
        while (n < 300 && bus.frame_error !== 1'b1) begin
            tick();
            n++;
        end
        chk("timeout_delay", W'(n), W'(99));
        chk("timeout_hdr_kept", bus.header_data, exp1);
        chk("timeout_valid", W'(bus.header_valid), W'(0));
        chk("timeout_busy", W'(bus.busy), W'(0));
        repeat (20) tick();
        chk("timeout_single_pulse", W'(ferr_cnt - f0), W'(1));

        // rdy held high three cycles in IDLE.
        r0 = rdy_cnt;
        send_hold(8'h33, 3);
        chk("held_rdy_one_accept", W'(rdy_cnt - r0), W'(1));
        chk("held_rdy_idle", W'(bus.busy), W'(0));

        // Async reset in the middle of a frame.
        send_hold(8'hA5, 1);
        for (int i = 0; i < 10; i++) send_hold(8'h60 + 8'(i), 1);
        chk("mid_frame_busy", W'(bus.busy), W'(1));
        f0 = ferr_cnt;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_header", bus.header_data, '0);
        chk("async_rst_busy", W'(bus.busy), W'(0));
        chk("async_rst_valid", W'(bus.header_valid), W'(0));
        chk("async_rst_rdy_clr", W'(bus.rdy_clr), W'(0));
        tick();
        tick();
        reset = 1'b1;
        repeat (150) tick();
        chk("rst_no_frame_error", W'(ferr_cnt - f0), W'(0));

        // Sync held three cycles; payload 80..CF contains A5 as data.
        send_frame(8'h80, 3, exp2);
        chk("hdr2_full", bus.header_data, exp2);
        bus.header_ack = 1'b1;
        tick();
        bus.header_ack = 1'b0;
        chk("ack2_valid_low", W'(bus.header_valid), W'(0));

`ifdef UART_HEADER_CHECKSUM_EN
        // All-FF payload: XOR of 80 x FF is 00.
        send_hold(8'hA5, 1);
        for (int i = 0; i < int'(HB); i++) send_hold(8'hFF, 1);
        send_last(8'h00);
        chk("cksum_ok_hdr", bus.header_data, {W{1'b1}});
        bus.header_ack = 1'b1;
        tick();
        bus.header_ack = 1'b0;
        f0 = ferr_cnt;
        send_hold(8'hA5, 1);
        for (int i = 0; i < int'(HB); i++) send_hold(8'hFF, 1);
        bus.rx_byte = 8'h01;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("cksum_bad_ferr", W'(bus.frame_error), W'(1));
        chk("cksum_bad_valid", W'(bus.header_valid), W'(0));
        bus.rx_rdy = 1'b0;
        tick();
        chk("cksum_bad_pulse_end", W'(bus.frame_error), W'(0));
        chk("cksum_bad_busy", W'(bus.busy), W'(0));
        chk("cksum_bad_hdr_kept", bus.header_data, {W{1'b1}});
        repeat (5) tick();
        chk("cksum_bad_single_pulse", W'(ferr_cnt - f0), W'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
